fetch_decode_unit: RTL and testbench
====================================

Name: fetch_decode_unit

Overview:
- Front end of the 5-stage LEGv8 pipelined CPU: PC register, 64-bit PC+4 adder, next-PC select, instruction ROM, IF/RF instruction register and field decoder.
- Supplies opcode, immediates and register specifiers to the RF stage.
- Receives branch redirects from the accelerated branch unit in RF, and stall/flush from hazard control.

Parameters:
- IMEM_WORDS, 1024, instruction memory depth in 32-bit words.
- PC_RESET, 64'h0, PC value after reset.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- en  in  1  pipeline advance; 0 = stall (PC and IR hold).
- flush  in  1  load IR with 0 (bubble) on the next edge.
- br_taken  in  1  select br_target as next PC.
- br_target  in  64  branch target from RF stage.
- prog_we  in  1  instruction memory write strobe (bench/loader).
- prog_addr  in  $clog2(IMEM_WORDS)  word index for prog_we.
- prog_data  in  32  word written when prog_we=1.
- pc  out  64  current fetch PC.
- pc_if  out  64  PC of the instruction held in IR.
- inst_if  out  32  IR contents.
- opcode  out  4  decoded operation.
- rd, rn, rm  out  5 each  inst_if[4:0], [9:5], [20:16].
- imm12  out  12  inst_if[21:10].
- imm9  out  9  inst_if[20:12].
- imm19  out  19  inst_if[23:5].
- imm26  out  26  inst_if[25:0].
- shamt  out  6  inst_if[15:10].

Behaviour:
- Reset (synchronous): pc=PC_RESET, inst_if=0, pc_if=0. Reset has priority over all other inputs. Memory contents are not cleared.
- Next PC: br_taken ? br_target : pc+4. Adder is 64-bit modular; 64'hFFFF_FFFF_FFFF_FFFC+4 wraps to 0.
- PC updates only when en=1; otherwise it holds. br_taken is ignored while en=0.
- Instruction memory:
  - Combinational read of word pc[2+:log2(IMEM_WORDS)]; pc[1:0] ignored.
  - Word index >= IMEM_WORDS, or pc[63:2+log2] nonzero, reads 32'h0.
  - Synchronous write when prog_we=1. A read of the same word in that cycle returns the old value.
  - Uninitialised words read 0.
- IR priority on each edge: reset > flush (inst_if=0, pc_if=0) > en (inst_if=mem[pc], pc_if=pc) > hold.
- Latency: the word at PC=A appears on inst_if, and its decode on the field outputs, one edge after pc==A with en=1.
- Field outputs are pure combinational slices of inst_if, valid for any encoding.
- opcode decode (first match; anything else = 4'h0, NOP/illegal):
  - inst[31:26]=000101 -> 4'h4 B
  - inst[31:24]=01010100 and inst[3:0]=1011 -> 4'h5 B.LT
  - inst[31:24]=10110100 -> 4'h6 CBZ
  - inst[31:22]=1001000100 -> 4'h1 ADDI
  - inst[31:21]=10101011000 -> 4'h2 ADDS
  - inst[31:21]=11101011000 -> 4'h3 SUBS
  - inst[31:21]=11111000010 -> 4'h7 LDUR
  - inst[31:21]=11111000000 -> 4'h8 STUR
  - inst[31:21]=10011011000 -> 4'h9 MUL
  - inst[31:21]=11010011010 -> 4'hA LSR
  - inst[31:21]=11010011011 -> 4'hB LSL
- opcode[0] is 1 for LSL and 0 for LSR; the shifter uses it as the direction select.
- inst_if=0 decodes to opcode 0 (bubble).

Test Plan:
- Reset then en=1, no branch: pc goes 0,4,8,12 on successive edges. inst_if lags by one cycle. After reset, inst_if=0 and opcode=0.
- Load word 0 = 32'h91000C21 (ADDI X1,X1,#3), word 1 = 32'hAB0200E3 (ADDS X3,X7,X2); run. Expect:
  - ADDI: opcode=1, rd=1, rn=1, imm12=3.
  - ADDS: opcode=2, rd=3, rn=7, rm=2.
- br_taken=1, br_target=64'h40 at pc=8 -> next pc=64'h40, then 64'h44. br_taken with en=0 -> pc holds at 8.
- en=0 for 3 cycles -> pc, pc_if and inst_if unchanged. flush=1 with en=0 -> inst_if=0, opcode=0, pc unchanged.
- Decode sweep: 32'h14000005 -> opcode 4, imm26=5; 32'hB4000041 -> opcode 6, imm19=2, rd=1; 32'hF84083E2 -> opcode 7, imm9=8; 32'hD37F1C41 -> opcode B, shamt=7; 32'hD35F1C41 -> opcode A; 32'hFFFFFFFF -> opcode 0.
- Assert reset mid-run at pc=64'h40 -> next edge pc=0, inst_if=0. Fetch at word index >= IMEM_WORDS -> inst_if=0.

Source files
------------

// File: rtl/fetch_decode_unit.sv
// LEGv8 pipeline front end: PC register, next-PC select, instruction ROM,
// IF/RF instruction register and combinational field decode.
module fetch_decode_unit #(
  parameter int unsigned IMEM_WORDS = 1024,
  parameter logic [63:0] PC_RESET   = 64'h0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          flush,
  input  logic                          br_taken,
  input  logic [63:0]                   br_target,
  input  logic                          prog_we,
  input  logic [$clog2(IMEM_WORDS)-1:0] prog_addr,
  input  logic [31:0]                   prog_data,
  output logic [63:0]                   pc,
  output logic [63:0]                   pc_if,
  output logic [31:0]                   inst_if,
  output logic [3:0]                    opcode,
  output logic [4:0]                    rd,
  output logic [4:0]                    rn,
  output logic [4:0]                    rm,
  output logic [11:0]                   imm12,
  output logic [8:0]                    imm9,
  output logic [18:0]                   imm19,
  output logic [25:0]                   imm26,
  output logic [5:0]                    shamt
);

  localparam int unsigned AW = $clog2(IMEM_WORDS);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_ADDS = 4'h2;
  localparam logic [3:0] OP_SUBS = 4'h3;
  localparam logic [3:0] OP_B    = 4'h4;
  localparam logic [3:0] OP_BLT  = 4'h5;
  localparam logic [3:0] OP_CBZ  = 4'h6;
  localparam logic [3:0] OP_LDUR = 4'h7;
  localparam logic [3:0] OP_STUR = 4'h8;
  localparam logic [3:0] OP_MUL  = 4'h9;
  localparam logic [3:0] OP_LSR  = 4'hA;
  localparam logic [3:0] OP_LSL  = 4'hB;

  logic [31:0]   mem [IMEM_WORDS];
  logic [61:0]   word_idx;
  logic          in_range;
  logic [31:0]   fetch_word;
  logic [63:0]   next_pc;

  // The whole word index (including high PC bits) must fall inside the ROM.
  assign word_idx   = pc[63:2];
  assign in_range   = word_idx < 62'(IMEM_WORDS);
  assign fetch_word = in_range ? mem[pc[2 +: AW]] : 32'h0;
  assign next_pc    = br_taken ? br_target : pc + 64'd4;

  // Loader port; combinational read above sees the old word in a write cycle.
  always_ff @(posedge clk) begin
    if (prog_we && (32'(prog_addr) < IMEM_WORDS)) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= PC_RESET;
    end else if (en) begin
      pc <= next_pc;
    end
  end

  // Flush inserts a bubble even when the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_if <= 32'h0;
      pc_if   <= 64'h0;
    end else if (flush) begin
      inst_if <= 32'h0;
      pc_if   <= 64'h0;
    end else if (en) begin
      inst_if <= fetch_word;
      pc_if   <= pc;
    end
  end

  assign rd    = inst_if[4:0];
  assign rn    = inst_if[9:5];
  assign rm    = inst_if[20:16];
  assign imm12 = inst_if[21:10];
  assign imm9  = inst_if[20:12];
  assign imm19 = inst_if[23:5];
  assign imm26 = inst_if[25:0];
  assign shamt = inst_if[15:10];

  // First-match decode; LSL/LSR differ only in opcode[0] (shift direction).
  always_comb begin
    opcode = OP_NOP;
    if (inst_if[31:26] == 6'b000101) begin
      opcode = OP_B;
    end else if (inst_if[31:24] == 8'b01010100 && inst_if[3:0] == 4'b1011) begin
      opcode = OP_BLT;
    end else if (inst_if[31:24] == 8'b10110100) begin
      opcode = OP_CBZ;
    end else if (inst_if[31:22] == 10'b1001000100) begin
      opcode = OP_ADDI;
    end else begin
      case (inst_if[31:21])
        11'b10101011000: opcode = OP_ADDS;
        11'b11101011000: opcode = OP_SUBS;
        11'b11111000010: opcode = OP_LDUR;
        11'b11111000000: opcode = OP_STUR;
        11'b10011011000: opcode = OP_MUL;
        11'b11010011010: opcode = OP_LSR;
        11'b11010011011: opcode = OP_LSL;
        default:         opcode = OP_NOP;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Directed bench for fetch_decode_unit: sequencing, stall, branch, flush,
// decode sweep, write/read collision, reset priority and out-of-range fetch.
module tb_fetch_decode_unit;

  localparam int unsigned IMEM_WORDS = 1024;
  localparam int unsigned AW = $clog2(IMEM_WORDS);

  logic          clk = 1'b0;
  logic          reset, en, flush, br_taken, prog_we;
  logic [63:0]   br_target;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_data;
  logic [63:0]   pc, pc_if;
  logic [31:0]   inst_if;
  logic [3:0]    opcode;
  logic [4:0]    rd, rn, rm;
  logic [11:0]   imm12;
  logic [8:0]    imm9;
  logic [18:0]   imm19;
  logic [25:0]   imm26;
  logic [5:0]    shamt;

  int n_cmp = 0;
  int n_err = 0;

  fetch_decode_unit #(.IMEM_WORDS(IMEM_WORDS), .PC_RESET(64'h0)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .br_taken(br_taken),
    .br_target(br_target), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .pc(pc), .pc_if(pc_if), .inst_if(inst_if),
    .opcode(opcode), .rd(rd), .rn(rn), .rm(rm), .imm12(imm12), .imm9(imm9),
    .imm19(imm19), .imm26(imm26), .shamt(shamt)
  );

  always #5 clk = ~clk;

  // One rising edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int unsigned a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = AW'(a); prog_data = d;
    step();
    prog_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; flush = 1'b0; br_taken = 1'b0; br_target = 64'h0;
    prog_we = 1'b0; prog_addr = '0; prog_data = 32'h0;
    #1;
    step();
    for (int i = 0; i < int'(IMEM_WORDS); i++) load(i, 32'h0);
    load(0, 32'h91000C21);
    load(1, 32'hAB0200E3);
    load(2, 32'h14000005);
    load(3, 32'hB4000041);
    load(4, 32'hF84083E2);
    load(5, 32'hD37F1C41);
    load(6, 32'hD35F1C41);
    load(7, 32'hFFFFFFFF);
    n_cmp++; if (pc !== 64'h0) begin n_err++; $display("FAIL rst_pc got=%h exp=%h", pc, 64'h0); end
    n_cmp++; if (inst_if !== 32'h0) begin n_err++; $display("FAIL rst_inst got=%h exp=%h", inst_if, 32'h0); end
    n_cmp++; if (pc_if !== 64'h0) begin n_err++; $display("FAIL rst_pc_if got=%h exp=%h", pc_if, 64'h0); end
    n_cmp++; if (opcode !== 4'h0) begin n_err++; $display("FAIL rst_opcode got=%h exp=%h", opcode, 4'h0); end
  endtask

  task automatic test_sequential();
    reset = 1'b0; en = 1'b1;
    step();
    n_cmp++; if (pc !== 64'h4) begin n_err++; $display("FAIL seq_pc1 got=%h exp=%h", pc, 64'h4); end
    n_cmp++; if (inst_if !== 32'h91000C21) begin n_err++; $display("FAIL seq_inst1 got=%h exp=%h", inst_if, 32'h91000C21); end
    n_cmp++; if (pc_if !== 64'h0) begin n_err++; $display("FAIL seq_pc_if1 got=%h exp=%h", pc_if, 64'h0); end
    n_cmp++; if (opcode !== 4'h1) begin n_err++; $display("FAIL addi_op got=%h exp=%h", opcode, 4'h1); end
    n_cmp++; if (rd !== 5'd1 || rn !== 5'd1) begin n_err++; $display("FAIL addi_regs got=%0d,%0d exp=1,1", rd, rn); end
    n_cmp++; if (imm12 !== 12'd3) begin n_err++; $display("FAIL addi_imm12 got=%0d exp=3", imm12); end
    step();
    n_cmp++; if (pc !== 64'h8) begin n_err++; $display("FAIL seq_pc2 got=%h exp=%h", pc, 64'h8); end
    n_cmp++; if (pc_if !== 64'h4) begin n_err++; $display("FAIL seq_pc_if2 got=%h exp=%h", pc_if, 64'h4); end
    n_cmp++; if (opcode !== 4'h2) begin n_err++; $display("FAIL adds_op got=%h exp=%h", opcode, 4'h2); end
    n_cmp++; if (rd !== 5'd3 || rn !== 5'd7 || rm !== 5'd2) begin n_err++; $display("FAIL adds_regs got=%0d,%0d,%0d exp=3,7,2", rd, rn, rm); end
  endtask

  task automatic test_stall();
    en = 1'b0;
    for (int i = 0; i < 3; i++) step();
    n_cmp++; if (pc !== 64'h8) begin n_err++; $display("FAIL stall_pc got=%h exp=%h", pc, 64'h8); end
    n_cmp++; if (pc_if !== 64'h4) begin n_err++; $display("FAIL stall_pc_if got=%h exp=%h", pc_if, 64'h4); end
    n_cmp++; if (inst_if !== 32'hAB0200E3) begin n_err++; $display("FAIL stall_inst got=%h exp=%h", inst_if, 32'hAB0200E3); end
    br_taken = 1'b1; br_target = 64'h40;
    step();
    n_cmp++; if (pc !== 64'h8) begin n_err++; $display("FAIL stall_br_pc got=%h exp=%h", pc, 64'h8); end
  endtask

  task automatic test_branch();
    en = 1'b1; br_taken = 1'b1; br_target = 64'h40;
    step();
    br_taken = 1'b0;
    n_cmp++; if (pc !== 64'h40) begin n_err++; $display("FAIL br_pc got=%h exp=%h", pc, 64'h40); end
    n_cmp++; if (opcode !== 4'h4 || imm26 !== 26'd5) begin n_err++; $display("FAIL b_decode got=%h/%0d exp=4/5", opcode, imm26); end
    n_cmp++; if (pc_if !== 64'h8) begin n_err++; $display("FAIL br_pc_if got=%h exp=%h", pc_if, 64'h8); end
    step();
    n_cmp++; if (pc !== 64'h44) begin n_err++; $display("FAIL br_pc_next got=%h exp=%h", pc, 64'h44); end
  endtask

  task automatic test_decode_sweep();
    br_taken = 1'b1; br_target = 64'hC;
    step();
    br_taken = 1'b0;
    step();
    n_cmp++; if (opcode !== 4'h6 || imm19 !== 19'd2 || rd !== 5'd1) begin n_err++; $display("FAIL cbz_decode got=%h/%0d/%0d exp=6/2/1", opcode, imm19, rd); end
    step();
    n_cmp++; if (opcode !== 4'h7 || imm9 !== 9'd8) begin n_err++; $display("FAIL ldur_decode got=%h/%0d exp=7/8", opcode, imm9); end
    step();
    n_cmp++; if (opcode !== 4'hB || shamt !== 6'd7) begin n_err++; $display("FAIL lsl_decode got=%h/%0d exp=b/7", opcode, shamt); end
    step();
    n_cmp++; if (opcode !== 4'hA) begin n_err++; $display("FAIL lsr_decode got=%h exp=a", opcode); end
    step();
    n_cmp++; if (inst_if !== 32'hFFFFFFFF || opcode !== 4'h0) begin n_err++; $display("FAIL ones_decode got=%h/%h exp=ffffffff/0", inst_if, opcode); end
    n_cmp++; if (pc !== 64'h20) begin n_err++; $display("FAIL sweep_pc got=%h exp=%h", pc, 64'h20); end
  endtask

  task automatic test_flush();
    en = 1'b0; flush = 1'b1;
    step();
    n_cmp++; if (inst_if !== 32'h0 || opcode !== 4'h0) begin n_err++; $display("FAIL flush_inst got=%h/%h exp=0/0", inst_if, opcode); end
    n_cmp++; if (pc !== 64'h20 || pc_if !== 64'h0) begin n_err++; $display("FAIL flush_pc got=%h/%h exp=20/0", pc, pc_if); end
    en = 1'b1;
    step();
    flush = 1'b0;
    n_cmp++; if (inst_if !== 32'h0 || pc !== 64'h24) begin n_err++; $display("FAIL flush_en got=%h/%h exp=0/24", inst_if, pc); end
  endtask

  task automatic test_write_collision();
    br_taken = 1'b1; br_target = 64'h0;
    step();
    br_taken = 1'b0;
    prog_we = 1'b1; prog_addr = '0; prog_data = 32'hD35F1C41;
    step();
    prog_we = 1'b0;
    n_cmp++; if (inst_if !== 32'h91000C21) begin n_err++; $display("FAIL coll_old got=%h exp=%h", inst_if, 32'h91000C21); end
    br_taken = 1'b1; br_target = 64'h0;
    step();
    br_taken = 1'b0;
    step();
    n_cmp++; if (inst_if !== 32'hD35F1C41 || opcode !== 4'hA) begin n_err++; $display("FAIL coll_new got=%h/%h exp=d35f1c41/a", inst_if, opcode); end
  endtask

  task automatic test_reset_midrun();
    br_taken = 1'b1; br_target = 64'h40;
    step();
    n_cmp++; if (pc !== 64'h40) begin n_err++; $display("FAIL mid_pre_pc got=%h exp=%h", pc, 64'h40); end
    reset = 1'b1; br_target = 64'h80;
    step();
    reset = 1'b0; br_taken = 1'b0;
    n_cmp++; if (pc !== 64'h0 || inst_if !== 32'h0 || pc_if !== 64'h0) begin n_err++; $display("FAIL mid_reset got=%h/%h/%h exp=0/0/0", pc, inst_if, pc_if); end
  endtask

  task automatic test_out_of_range();
    br_taken = 1'b1; br_target = 64'h1000;
    step();
    br_target = 64'h8000_0000_0000_0000;
    step();
    n_cmp++; if (inst_if !== 32'h0 || pc_if !== 64'h1000) begin n_err++; $display("FAIL oor_idx got=%h/%h exp=0/1000", inst_if, pc_if); end
    br_target = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    br_taken = 1'b0;
    n_cmp++; if (inst_if !== 32'h0) begin n_err++; $display("FAIL oor_high got=%h exp=0", inst_if); end
    step();
    n_cmp++; if (pc !== 64'h0) begin n_err++; $display("FAIL wrap_pc got=%h exp=0", pc); end
    step();
    n_cmp++; if (inst_if !== 32'hD35F1C41 || pc_if !== 64'h0) begin n_err++; $display("FAIL wrap_fetch got=%h/%h exp=d35f1c41/0", inst_if, pc_if); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_decode_sweep();
    test_flush();
    test_write_collision();
    test_reset_midrun();
    test_out_of_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
